rr_mux_arbiter: RTL

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter.sv | 45 ++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin 3:1 arbiter; A/B/C valid-ready inputs, grant S (3=none), registered Y/y_valid with y_ready backpressure
module rr_mux_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] A,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] B,
  output logic             b_ready,
  input  logic             c_valid,
  input  logic [WIDTH-1:0] C,
  output logic             c_ready,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid,
  input  logic             y_ready
);
  logic [1:0] lg, p0, p1;
  logic [2:0] v;
  logic can_accept, accept;
  always_comb begin
    v = {c_valid, b_valid, a_valid};
    p0 = lg == 2'd2 ? 2'd0 : lg + 2'd1;
    p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    S = v[p0] ? p0 : v[p1] ? p1 : v[lg] ? lg : 2'd3;
    can_accept = !rst && (!y_valid || y_ready);
    accept = S != 2'd3 && can_accept;
    a_ready = accept && S == 2'd0;
    b_ready = accept && S == 2'd1;
    c_ready = accept && S == 2'd2;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      y_valid <= 1'b0;
      Y <= '0;
      lg <= 2'd2;
    end else if (accept) begin
      Y <= S == 2'd0 ? A : S == 2'd1 ? B : C;
      y_valid <= 1'b1;
      lg <= S;
    end else if (y_ready) y_valid <= 1'b0;
endmodule
